if_stage_oq: RTL
================

Name: if_stage_oq

Overview:
- Parametrised successor to the single-slot fetch stage: pre-IF/IF pair supporting up to MAX_OUTSTANDING in-flight inst-SRAM requests (addr_ok/data_ok protocol) and an IBUF_DEPTH-entry instruction buffer feeding ID.
- Handles branch/exception redirects by flushing the buffer and discarding stale in-flight responses via a counter, with no cancel-state stalls.
- Sits between the inst-SRAM bridge and the decode stage.

Parameters:
- MAX_OUTSTANDING, 2, max requests accepted (addr_ok) but not yet answered (data_ok); 1..4.
- IBUF_DEPTH, 4, instruction buffer entries; power of two, >= MAX_OUTSTANDING.
- RESET_PC, 32'h1c000000, first fetch address after reset.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- ds_allowin  in  1  ID can accept an instruction this cycle.
- br_valid  in  1  ID branch redirect (taken).
- br_stall  in  1  ID branch unresolved; suppress new requests.
- br_target  in  32  branch target.
- flush_valid  in  1  WB exception/ertn redirect; overrides br_valid.
- flush_target  in  32  exception entry or ERA, selected by WB.
- inst_sram_req  out  1  request valid.
- inst_sram_addr  out  32  request address.
- inst_sram_size  out  2  constant 2'b10.
- inst_sram_addr_ok  in  1  request accepted.
- inst_sram_data_ok  in  1  response valid.
- inst_sram_rdata  in  32  response data.
- fs_to_ds_valid  out  1  head entry valid.
- fs_to_ds_pc  out  32  head PC.
- fs_to_ds_inst  out  32  head instruction; 32'h00100000 (nop encoding) when ex.
- fs_to_ds_ex  out  1  ADEF exception on head entry (ecode ADE, esubcode ADEF decoded downstream).

Behaviour:
- Reset: fetch_pc=RESET_PC; outstanding=0; discard=0; ibuf empty; adef_hold=0. All outputs 0 except inst_sram_size=2'b10. The first request is issued in the cycle after reset deasserts.
- Issue: inst_sram_req = ~reset & ~br_stall & ~adef_hold & ~redirect & (outstanding < MAX_OUTSTANDING) & (ibuf_count + outstanding - discard < IBUF_DEPTH), where redirect = br_valid | flush_valid. inst_sram_addr = fetch_pc. Req and addr are held stable until addr_ok.
- On req & addr_ok: push fetch_pc into pc_queue (depth MAX_OUTSTANDING); fetch_pc += 4 (32-bit wrap); outstanding += 1.
- ADEF: if fetch_pc[1:0] != 0 and no redirect, issue no request and push {pc, nop, ex=1} into ibuf once room exists (counted like a request). Set adef_hold, which blocks issue until the next redirect.
- Response: each data_ok pops pc_queue; outstanding -= 1.
  - If discard > 0, the response is dropped and discard -= 1.
  - Otherwise {pc, rdata, 0} is pushed into ibuf. Responses are in order.
- Redirect in cycle N (flush_valid priority, else br_valid):
  - ibuf cleared.
  - discard <= outstanding + (req & addr_ok in N) - (data_ok in N).
  - fetch_pc <= target; adef_hold <= 0.
  - A data_ok in N is always discarded.
  - No request is issued in N. A new request to the target is issued in N+1.
- Output: fs_to_ds_valid = ibuf non-empty & ~redirect. Pop on valid & ds_allowin.
- Simultaneous push and pop on a full ibuf is legal. The credit rule guarantees no overflow; underflow is impossible by construction.
- br_stall with outstanding requests: responses continue to fill the ibuf; issue is suppressed only.
- Reset mid-operation: all state clears. Late data_ok arriving after reset are ignored while outstanding == 0 (the bridge is also reset).

Optional Feature:
- IF_PERF_CNT_EN: adds outputs perf_discard_cnt[31:0] (responses dropped) and perf_starve_cnt[31:0] (cycles with ds_allowin=1 & fs_to_ds_valid=0). Both reset to 0, wrap at 2^32, and increment one cycle after the event.
- Without the macro, these ports and counters are absent.

Test Plan:
- Reset, then addr_ok/data_ok each with 1-cycle latency, ds_allowin=1 -> requests to 1c000000, 1c000004, ...; fs_to_ds carries matching pc/rdata in order; up to 2 outstanding.
- Hold ds_allowin=0 for 10 cycles -> ibuf fills to 4; req stays 0 when ibuf_count + outstanding = 4; on release, entries pop 1c000000..1c00000c in order.
- Two requests outstanding, br_valid with br_target=1c000100 -> both responses dropped (discard 2→0); next fs_to_ds_pc = 1c000100.
- flush_valid and br_valid in the same cycle, flush_target=1c008000 -> next delivered pc = 1c008000; the branch is ignored.
- br_target=1c000102 -> no SRAM request; fs_to_ds_ex=1, pc=1c000102, inst=00100000; fetch halts until flush_valid to 1c008000, then resumes there.
- With IF_PERF_CNT_EN: in the redirect scenario above, perf_discard_cnt = 2.

Source files
------------

// File: rtl/if_stage_oq.sv
// Fetch stage with up to MAX_OUTSTANDING in-flight inst-SRAM requests and an instruction buffer.
// Define IF_PERF_CNT_EN to add the discard and starvation performance counters.
module if_stage_oq #(
    parameter int          MAX_OUTSTANDING = 2,
    parameter int          IBUF_DEPTH      = 4,
    parameter logic [31:0] RESET_PC        = 32'h1c000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ds_allowin,
    input  logic        br_valid,
    input  logic        br_stall,
    input  logic [31:0] br_target,
    input  logic        flush_valid,
    input  logic [31:0] flush_target,
    output logic        inst_sram_req,
    output logic [31:0] inst_sram_addr,
    output logic [1:0]  inst_sram_size,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic [31:0] inst_sram_rdata,
`ifdef IF_PERF_CNT_EN
    output logic [31:0] perf_discard_cnt,
    output logic [31:0] perf_starve_cnt,
`endif
    output logic        fs_to_ds_valid,
    output logic [31:0] fs_to_ds_pc,
    output logic [31:0] fs_to_ds_inst,
    output logic        fs_to_ds_ex
);

    localparam int QW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int BW = (IBUF_DEPTH > 1) ? $clog2(IBUF_DEPTH) : 1;
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int CW = $clog2(IBUF_DEPTH + 1);
    localparam logic [31:0] NOP = 32'h00100000;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [OW-1:0] out_q, out_d, disc_q, disc_d;
    logic          adef_hold_q, adef_hold_d;
    logic          req_hold_q, req_hold_d;
    logic [31:0]   pcq_q [MAX_OUTSTANDING];
    logic [31:0]   pcq_d [MAX_OUTSTANDING];
    logic [QW-1:0] pcq_wr_q, pcq_wr_d, pcq_rd_q, pcq_rd_d;
    logic [31:0]   ib_pc_q [IBUF_DEPTH];
    logic [31:0]   ib_pc_d [IBUF_DEPTH];
    logic [31:0]   ib_inst_q [IBUF_DEPTH];
    logic [31:0]   ib_inst_d [IBUF_DEPTH];
    logic          ib_ex_q [IBUF_DEPTH];
    logic          ib_ex_d [IBUF_DEPTH];
    logic [BW-1:0] ib_head_q, ib_head_d, ib_tail_q, ib_tail_d;
    logic [CW-1:0] ib_cnt_q, ib_cnt_d;

    logic        redirect, misalign, credit_ok, room_ok;
    logic        adef_fire, accept, resp, drop, push, pop;
    logic [31:0] target;

    function automatic logic [QW-1:0] qinc(input logic [QW-1:0] p);
        return (32'(p) == MAX_OUTSTANDING - 1) ? '0 : p + QW'(1);
    endfunction

    function automatic logic [BW-1:0] binc(input logic [BW-1:0] p);
        return (32'(p) == IBUF_DEPTH - 1) ? '0 : p + BW'(1);
    endfunction

    // Credits count buffered entries plus responses still owed to the buffer.
    always_comb begin
        redirect  = br_valid | flush_valid;
        target    = flush_valid ? flush_target : br_target;
        misalign  = fetch_pc_q[1:0] != 2'b00;
        credit_ok = (32'(ib_cnt_q) + 32'(out_q) - 32'(disc_q))
                    < 32'(IBUF_DEPTH);
        room_ok   = ~reset & ~br_stall & ~adef_hold_q & ~redirect & credit_ok;
        inst_sram_req = (room_ok & ~misalign
                         & (32'(out_q) < 32'(MAX_OUTSTANDING)))
                      | (req_hold_q & ~reset & ~redirect);
        inst_sram_addr = reset ? '0 : fetch_pc_q;
        inst_sram_size = 2'b10;
        adef_fire = room_ok & misalign & (out_q == disc_q);
        accept    = inst_sram_req & inst_sram_addr_ok;
        resp      = ~reset & inst_sram_data_ok & (out_q != '0);
        drop      = resp & (redirect | (disc_q != '0));
        push      = (resp & ~drop) | adef_fire;
        fs_to_ds_valid = ~reset & (ib_cnt_q != '0) & ~redirect;
        pop            = fs_to_ds_valid & ds_allowin;
        fs_to_ds_pc    = fs_to_ds_valid ? ib_pc_q[ib_head_q] : '0;
        fs_to_ds_inst  = fs_to_ds_valid ? ib_inst_q[ib_head_q] : '0;
        fs_to_ds_ex    = fs_to_ds_valid & ib_ex_q[ib_head_q];
    end

    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        out_d       = out_q + OW'(accept) - OW'(resp);
        disc_d      = disc_q;
        adef_hold_d = adef_hold_q;
        req_hold_d  = inst_sram_req & ~inst_sram_addr_ok;
        pcq_d       = pcq_q;
        pcq_wr_d    = pcq_wr_q;
        pcq_rd_d    = pcq_rd_q;
        ib_pc_d     = ib_pc_q;
        ib_inst_d   = ib_inst_q;
        ib_ex_d     = ib_ex_q;
        ib_head_d   = ib_head_q;
        ib_tail_d   = ib_tail_q;
        ib_cnt_d    = ib_cnt_q + CW'(push) - CW'(pop);
        if (accept) begin
            pcq_d[pcq_wr_q] = fetch_pc_q;
            pcq_wr_d        = qinc(pcq_wr_q);
            fetch_pc_d      = fetch_pc_q + 32'd4;
        end
        if (resp)
            pcq_rd_d = qinc(pcq_rd_q);
        if (drop && !redirect)
            disc_d = disc_q - OW'(1);
        if (adef_fire)
            adef_hold_d = 1'b1;
        if (push) begin
            ib_pc_d[ib_tail_q]   = adef_fire ? fetch_pc_q : pcq_q[pcq_rd_q];
            ib_inst_d[ib_tail_q] = adef_fire ? NOP : inst_sram_rdata;
            ib_ex_d[ib_tail_q]   = adef_fire;
            ib_tail_d            = binc(ib_tail_q);
        end
        if (pop)
            ib_head_d = binc(ib_head_q);
        // Every response still owed after this cycle belongs to the old path.
        if (redirect) begin
            ib_head_d   = '0;
            ib_tail_d   = '0;
            ib_cnt_d    = '0;
            disc_d      = out_d;
            fetch_pc_d  = target;
            adef_hold_d = 1'b0;
            req_hold_d  = 1'b0;
        end
        if (reset) begin
            fetch_pc_d  = RESET_PC;
            out_d       = '0;
            disc_d      = '0;
            adef_hold_d = 1'b0;
            req_hold_d  = 1'b0;
            pcq_wr_d    = '0;
            pcq_rd_d    = '0;
            ib_head_d   = '0;
            ib_tail_d   = '0;
            ib_cnt_d    = '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++)
                pcq_d[i] = '0;
            for (int i = 0; i < IBUF_DEPTH; i++) begin
                ib_pc_d[i]   = '0;
                ib_inst_d[i] = '0;
                ib_ex_d[i]   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        fetch_pc_q  <= fetch_pc_d;
        out_q       <= out_d;
        disc_q      <= disc_d;
        adef_hold_q <= adef_hold_d;
        req_hold_q  <= req_hold_d;
        pcq_q       <= pcq_d;
        pcq_wr_q    <= pcq_wr_d;
        pcq_rd_q    <= pcq_rd_d;
        ib_pc_q     <= ib_pc_d;
        ib_inst_q   <= ib_inst_d;
        ib_ex_q     <= ib_ex_d;
        ib_head_q   <= ib_head_d;
        ib_tail_q   <= ib_tail_d;
        ib_cnt_q    <= ib_cnt_d;
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_disc_q, perf_disc_d, perf_starve_q, perf_starve_d;

    always_comb begin
        perf_disc_d   = perf_disc_q + 32'(drop);
        perf_starve_d = perf_starve_q + 32'(ds_allowin & ~fs_to_ds_valid);
        if (reset) begin
            perf_disc_d   = '0;
            perf_starve_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        perf_disc_q   <= perf_disc_d;
        perf_starve_q <= perf_starve_d;
    end

    assign perf_discard_cnt = perf_disc_q;
    assign perf_starve_cnt  = perf_starve_q;
`endif

endmodule
